// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// Countdown companion to the stopwatch in the multi-mode clock. A preset
// hour/minute/second value is latched with load and then decremented by one
// second on every clk_out edge while start is held high. When the count
// reaches zero the block parks in DONE with done high and pulses alarm for
// exactly one cycle.
//
// Optional build macro:
//   AUTO_RELOAD_EN - instead of stopping at zero, the final 0:00:01 edge
//                    reloads the last preset, stays in RUN and pulses alarm
//                    (periodic timer). A zero preset still ends in DONE.
//
// Ports:
//   clk_out     in   1  divided real-time clock, all logic on posedge
//   rst         in   1  asynchronous reset, active-high
//   load        in   1  latch preset values (highest priority)
//   set_hour    in   8  preset hour   (clamped to HOUR-1)
//   set_minute  in   8  preset minute (clamped to MINUTE-1)
//   set_second  in   8  preset second (clamped to SECOND-1)
//   start       in   1  run enable, high = run, low = pause
//   cur_hour    out  8  remaining hours
//   cur_minute  out  8  remaining minutes
//   cur_second  out  8  remaining seconds
//   state       out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
//   done        out  1  high while state is DONE
//   alarm       out  1  one-cycle pulse when the count expires
// ---------------------------------------------------------------------------
module countdown_timer #(
    parameter int HOUR   = 5,
    parameter int MINUTE = 3,
    parameter int SECOND = 21
) (
    input  logic       clk_out,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_minute,
    input  logic [7:0] set_second,
    input  logic       start,
    output logic [7:0] cur_hour,
    output logic [7:0] cur_minute,
    output logic [7:0] cur_second,
    output logic [1:0] state,
    output logic       done,
    output logic       alarm
);

    // Largest legal value of each field, kept 8 bits wide so every
    // comparison and assignment below is width-matched.
    localparam logic [7:0] HOUR_MAX   = 8'(HOUR - 1);
    localparam logic [7:0] MINUTE_MAX = 8'(MINUTE - 1);
    localparam logic [7:0] SECOND_MAX = 8'(SECOND - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_r;

    logic [7:0] clamp_hour;
    logic [7:0] clamp_minute;
    logic [7:0] clamp_second;

    logic [7:0] dec_hour;
    logic [7:0] dec_minute;
    logic [7:0] dec_second;

    logic count_zero;
    logic count_one;

`ifdef AUTO_RELOAD_EN
    logic [7:0] shadow_hour;
    logic [7:0] shadow_minute;
    logic [7:0] shadow_second;
    logic       shadow_zero;
`endif

    assign state = state_r;

    // Out-of-range presets saturate at the top of their field so the count
    // can never hold a value the borrow logic does not expect.
    always_comb begin
        clamp_hour   = (set_hour   > HOUR_MAX)   ? HOUR_MAX   : set_hour;
        clamp_minute = (set_minute > MINUTE_MAX) ? MINUTE_MAX : set_minute;
        clamp_second = (set_second > SECOND_MAX) ? SECOND_MAX : set_second;
    end

    // One-second decrement with borrow. Hour is never decremented from
    // zero because this path is only taken while the count is above 0:00:01.
    always_comb begin
        dec_hour   = cur_hour;
        dec_minute = cur_minute;
        dec_second = cur_second - 8'd1;
        if (cur_second == 8'd0) begin
            dec_second = SECOND_MAX;
            if (cur_minute == 8'd0) begin
                dec_minute = MINUTE_MAX;
                dec_hour   = cur_hour - 8'd1;
            end else begin
                dec_minute = cur_minute - 8'd1;
            end
        end
    end

    assign count_zero = (cur_hour == 8'd0) && (cur_minute == 8'd0) &&
                        (cur_second == 8'd0);
    assign count_one  = (cur_hour == 8'd0) && (cur_minute == 8'd0) &&
                        (cur_second == 8'd1);

`ifdef AUTO_RELOAD_EN
    assign shadow_zero = (shadow_hour == 8'd0) && (shadow_minute == 8'd0) &&
                         (shadow_second == 8'd0);

    // Shadow copy of the last clamped preset, used to restart the count.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            shadow_hour   <= 8'd0;
            shadow_minute <= 8'd0;
            shadow_second <= 8'd0;
        end else if (load) begin
            shadow_hour   <= clamp_hour;
            shadow_minute <= clamp_minute;
            shadow_second <= clamp_second;
        end
    end
`endif

    // Main control FSM. alarm defaults low every edge so it can only ever
    // be high for the single cycle after the edge that sets it.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cur_hour   <= 8'd0;
            cur_minute <= 8'd0;
            cur_second <= 8'd0;
            done       <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            alarm <= 1'b0;
            if (load) begin
                cur_hour   <= clamp_hour;
                cur_minute <= clamp_minute;
                cur_second <= clamp_second;
                state_r    <= IDLE;
                done       <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            if (count_zero) begin
                                state_r <= DONE;
                                done    <= 1'b1;
                                alarm   <= 1'b1;
                            end else begin
                                state_r <= RUN;
                            end
                        end
                    end

                    RUN: begin
                        if (!start) begin
                            state_r <= PAUSE;
                        end else if (count_zero) begin
                            // Unreachable in normal use; parks safely.
                            state_r <= DONE;
                            done    <= 1'b1;
                            alarm   <= 1'b1;
                        end else if (count_one) begin
`ifdef AUTO_RELOAD_EN
                            alarm <= 1'b1;
                            if (shadow_zero) begin
                                cur_hour   <= 8'd0;
                                cur_minute <= 8'd0;
                                cur_second <= 8'd0;
                                state_r    <= DONE;
                                done       <= 1'b1;
                            end else begin
                                cur_hour   <= shadow_hour;
                                cur_minute <= shadow_minute;
                                cur_second <= shadow_second;
                            end
`else
                            cur_hour   <= 8'd0;
                            cur_minute <= 8'd0;
                            cur_second <= 8'd0;
                            state_r    <= DONE;
                            done       <= 1'b1;
                            alarm      <= 1'b1;
`endif
                        end else begin
                            cur_hour   <= dec_hour;
                            cur_minute <= dec_minute;
                            cur_second <= dec_second;
                        end
                    end

                    PAUSE: begin
                        if (start) begin
                            state_r <= RUN;
                        end
                    end

                    DONE: begin
                        cur_hour   <= 8'd0;
                        cur_minute <= 8'd0;
                        cur_second <= 8'd0;
                        done       <= 1'b1;
                    end

                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
